// File: rtl/axi_sram_wr_bridge.sv
// AXI AW/W/B responder turning write bursts into single-beat SRAM writes; one burst in flight.
// Latency: SRAM write one cycle after each W handshake; B raised the cycle after the last beat.
// Backpressure: wready only while a burst is open; bvalid holds until bready; no new AW until B completes.
module axi_sram_wr_bridge #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int LEN_W  = 8
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [ID_W-1:0]       m_awid,
    input  logic [ADDR_W-1:0]     m_awaddr,
    input  logic [LEN_W-1:0]      m_awlen,
    input  logic [2:0]            m_awsize,
    input  logic [1:0]            m_awburst,
    input  logic [1:0]            m_awlock,
    input  logic [3:0]            m_awcache,
    input  logic [2:0]            m_awprot,
    input  logic                  m_awvalid,
    output logic                  m_awready,
    input  logic [ID_W-1:0]       m_wid,
    input  logic [DATA_W-1:0]     m_wdata,
    input  logic [DATA_W/8-1:0]   m_wstrb,
    input  logic                  m_wlast,
    input  logic                  m_wvalid,
    output logic                  m_wready,
    output logic [ID_W-1:0]       m_bid,
    output logic [1:0]            m_bresp,
    output logic                  m_bvalid,
    input  logic                  m_bready,
    output logic [ADDR_W-1:0]     ram_waddr,
    output logic [DATA_W-1:0]     ram_wdata,
    output logic [DATA_W/8-1:0]   ram_wen
);

    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    state_t              state, state_n;
    logic [ID_W-1:0]     id_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    cnt_q;
    logic [2:0]          size_q;
    logic [1:0]          burst_q;
    logic                err_q;

    logic aw_hs, w_hs, b_hs, beat_last, err_n, wrap_ok;
    logic [ADDR_W-1:0] step, aligned, incr_addr, wrap_mask, wrap_addr, next_addr;

    logic unused_inputs;
    assign unused_inputs = ^{m_awlock, m_awcache, m_awprot, m_wid};

    assign aw_hs     = m_awvalid & m_awready;
    assign w_hs      = m_wvalid & m_wready;
    assign b_hs      = m_bready & m_bvalid;
    assign beat_last = (cnt_q == len_q);
    assign err_n     = err_q | (m_wlast != beat_last);
    assign wrap_ok   = (m_awlen == LEN_W'(1)) || (m_awlen == LEN_W'(3)) ||
                       (m_awlen == LEN_W'(7)) || (m_awlen == LEN_W'(15));

    // Later beats step from the size-aligned address so an unaligned start realigns after beat 0.
    always_comb begin
        step      = ADDR_W'(1) << size_q;
        aligned   = addr_q & ~(step - ADDR_W'(1));
        incr_addr = aligned + step;
        wrap_mask = ((ADDR_W'(len_q) + ADDR_W'(1)) << size_q) - ADDR_W'(1);
        wrap_addr = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
        case (burst_q)
            BURST_FIXED: next_addr = addr_q;
            BURST_WRAP:  next_addr = wrap_addr;
            default:     next_addr = incr_addr;
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (aw_hs) state_n = DATA;
            DATA:    if (w_hs && beat_last) state_n = RESP;
            RESP:    if (b_hs) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state     <= IDLE;
            m_awready <= 1'b0;
            m_wready  <= 1'b0;
            m_bvalid  <= 1'b0;
            m_bid     <= '0;
            m_bresp   <= 2'b00;
            ram_waddr <= '0;
            ram_wdata <= '0;
            ram_wen   <= '0;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            size_q    <= '0;
            burst_q   <= BURST_INCR;
            err_q     <= 1'b0;
        end else begin
            state     <= state_n;
            m_awready <= (state_n == IDLE);
            m_wready  <= (state_n == DATA);
            m_bvalid  <= (state_n == RESP);
            ram_wen   <= '0;
            if (aw_hs) begin
                id_q   <= m_awid;
                addr_q <= m_awaddr;
                len_q  <= m_awlen;
                size_q <= m_awsize;
                cnt_q  <= '0;
                // Illegal WRAP lengths fall back to INCR and are reported as SLVERR.
                burst_q <= (m_awburst == BURST_WRAP && !wrap_ok) ? BURST_INCR : m_awburst;
                err_q   <= (m_awburst == BURST_RSVD) || (m_awburst == BURST_WRAP && !wrap_ok);
            end
            if (w_hs) begin
                ram_waddr <= addr_q;
                ram_wdata <= m_wdata;
                ram_wen   <= (burst_q == BURST_RSVD) ? '0 : m_wstrb;
                addr_q    <= next_addr;
                cnt_q     <= cnt_q + LEN_W'(1);
                err_q     <= err_n;
                if (beat_last) begin
                    m_bid   <= id_q;
                    m_bresp <= err_n ? 2'b10 : 2'b00;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_sram_wr_bridge.sv
// Directed bench for axi_sram_wr_bridge: single, INCR, WRAP, FIXED, error, backpressure and reset scenarios.
module tb_axi_sram_wr_bridge;

    logic        aclk = 1'b0;
    logic        areset;
    logic [3:0]  m_awid;
    logic [31:0] m_awaddr;
    logic [7:0]  m_awlen;
    logic [2:0]  m_awsize;
    logic [1:0]  m_awburst;
    logic        m_awvalid;
    logic        m_awready;
    logic [63:0] m_wdata;
    logic [7:0]  m_wstrb;
    logic        m_wlast;
    logic        m_wvalid;
    logic        m_wready;
    logic [3:0]  m_bid;
    logic [1:0]  m_bresp;
    logic        m_bvalid;
    logic        m_bready;
    logic [31:0] ram_waddr;
    logic [63:0] ram_wdata;
    logic [7:0]  ram_wen;

    int checks = 0;
    int fails  = 0;

    always #5 aclk = ~aclk;

    axi_sram_wr_bridge dut (
        .aclk(aclk), .areset(areset),
        .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
        .m_awburst(m_awburst), .m_awlock(2'b00), .m_awcache(4'h0), .m_awprot(3'b000),
        .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wid(4'h0), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_wen(ram_wen)
    );

    // Stimulus helpers: every call returns 1 time unit after the sampling edge.
    task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        m_awid = id; m_awaddr = addr; m_awlen = len; m_awsize = size; m_awburst = burst;
        m_awvalid = 1'b1;
        @(posedge aclk); #1;
        m_awvalid = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] data, input logic [7:0] strb, input logic last);
        m_wdata = data; m_wstrb = strb; m_wlast = last; m_wvalid = 1'b1;
        @(posedge aclk); #1;
    endtask

    task automatic do_b();
        m_bready = 1'b1;
        @(posedge aclk); #1;
        m_bready = 1'b0;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        m_awvalid = 0; m_wvalid = 0; m_bready = 0; m_wlast = 0;
        m_awid = 0; m_awaddr = 0; m_awlen = 0; m_awsize = 0; m_awburst = 0;
        m_wdata = 0; m_wstrb = 0;
        repeat (3) @(posedge aclk);
        #1;
        checks++; if (m_awready !== 1'b0) begin fails++; $display("FAIL rst_awready: got %b expected 0", m_awready); end
        checks++; if ({m_wready, m_bvalid, m_bid, m_bresp} !== 8'h00) begin fails++; $display("FAIL rst_handshake: got %h expected 00", {m_wready, m_bvalid, m_bid, m_bresp}); end
        checks++; if ({ram_waddr, ram_wdata, ram_wen} !== 104'h0) begin fails++; $display("FAIL rst_ram: got %h expected 0", {ram_waddr, ram_wdata, ram_wen}); end
        areset = 1'b0;
        @(posedge aclk); #1;
        checks++; if (m_awready !== 1'b1) begin fails++; $display("FAIL rst_release_awready: got %b expected 1", m_awready); end
        checks++; if (m_wready !== 1'b0) begin fails++; $display("FAIL rst_release_wready: got %b expected 0", m_wready); end
    endtask

    task automatic test_single();
        do_aw(4'd3, 32'h1C000008, 8'd0, 3'd3, 2'b01);
        checks++; if ({m_awready, m_wready} !== 2'b01) begin fails++; $display("FAIL single_ready: got %b expected 01", {m_awready, m_wready}); end
        send_beat(64'h1122334455667788, 8'hFF, 1'b1);
        m_wvalid = 0;
        checks++; if (ram_waddr !== 32'h1C000008) begin fails++; $display("FAIL single_addr: got %h expected 1c000008", ram_waddr); end
        checks++; if (ram_wdata !== 64'h1122334455667788) begin fails++; $display("FAIL single_data: got %h expected 1122334455667788", ram_wdata); end
        checks++; if (ram_wen !== 8'hFF) begin fails++; $display("FAIL single_wen: got %h expected ff", ram_wen); end
        checks++; if ({m_bvalid, m_bid, m_bresp, m_wready} !== 8'b1_0011_00_0) begin fails++; $display("FAIL single_b: got %b expected 10011000", {m_bvalid, m_bid, m_bresp, m_wready}); end
        do_b();
        checks++; if ({m_bvalid, m_awready, ram_wen} !== 10'b01_00000000) begin fails++; $display("FAIL single_after_b: got %b expected 0100000000", {m_bvalid, m_awready, ram_wen}); end
    endtask

    task automatic test_incr();
        do_aw(4'd5, 32'h1C000000, 8'd3, 3'd3, 2'b01);
        for (int i = 0; i < 4; i++) begin
            send_beat(64'hA0 + 64'(i), 8'hFF, i == 3);
            checks++; if (ram_waddr !== 32'h1C000000 + 32'(8 * i)) begin fails++; $display("FAIL incr_addr%0d: got %h expected %h", i, ram_waddr, 32'h1C000000 + 32'(8 * i)); end
            checks++; if ({ram_wen, ram_wdata} !== {8'hFF, 64'hA0 + 64'(i)}) begin fails++; $display("FAIL incr_wr%0d: got %h expected %h", i, {ram_wen, ram_wdata}, {8'hFF, 64'hA0 + 64'(i)}); end
        end
        m_wvalid = 0;
        checks++; if ({m_bvalid, m_bid, m_bresp} !== 7'b1_0101_00) begin fails++; $display("FAIL incr_b: got %b expected 1010100", {m_bvalid, m_bid, m_bresp}); end
        do_b();
    endtask

    task automatic test_wrap_fixed();
        logic [31:0] wexp [4] = '{32'h1C000010, 32'h1C000018, 32'h1C000000, 32'h1C000008};
        do_aw(4'd6, 32'h1C000010, 8'd3, 3'd3, 2'b10);
        for (int i = 0; i < 4; i++) begin
            send_beat(64'hB0 + 64'(i), 8'h0F, i == 3);
            checks++; if (ram_waddr !== wexp[i]) begin fails++; $display("FAIL wrap_addr%0d: got %h expected %h", i, ram_waddr, wexp[i]); end
            checks++; if (ram_wen !== 8'h0F) begin fails++; $display("FAIL wrap_wen%0d: got %h expected 0f", i, ram_wen); end
        end
        m_wvalid = 0;
        checks++; if ({m_bvalid, m_bresp} !== 3'b100) begin fails++; $display("FAIL wrap_b: got %b expected 100", {m_bvalid, m_bresp}); end
        do_b();
        do_aw(4'd7, 32'h1C000040, 8'd2, 3'd3, 2'b00);
        for (int i = 0; i < 3; i++) begin
            send_beat(64'hC0 + 64'(i), 8'hFF, i == 2);
            checks++; if ({ram_waddr, ram_wen} !== {32'h1C000040, 8'hFF}) begin fails++; $display("FAIL fixed_wr%0d: got %h expected 1c000040ff", i, {ram_waddr, ram_wen}); end
        end
        m_wvalid = 0;
        checks++; if ({m_bvalid, m_bid, m_bresp} !== 7'b1_0111_00) begin fails++; $display("FAIL fixed_b: got %b expected 1011100", {m_bvalid, m_bid, m_bresp}); end
        do_b();
    endtask

    task automatic test_errors();
        do_aw(4'd2, 32'h1C000100, 8'd3, 3'd3, 2'b01);
        for (int i = 0; i < 4; i++) begin
            send_beat(64'hD0 + 64'(i), 8'hFF, i == 1);
            checks++; if ({ram_waddr, ram_wen} !== {32'h1C000100 + 32'(8 * i), 8'hFF}) begin fails++; $display("FAIL early_last_wr%0d: got %h expected %h", i, {ram_waddr, ram_wen}, {32'h1C000100 + 32'(8 * i), 8'hFF}); end
            checks++; if (m_bvalid !== (i == 3)) begin fails++; $display("FAIL early_last_bvalid%0d: got %b expected %b", i, m_bvalid, i == 3); end
        end
        m_wvalid = 0;
        checks++; if ({m_bid, m_bresp} !== 6'b0010_10) begin fails++; $display("FAIL early_last_bresp: got %b expected 001010", {m_bid, m_bresp}); end
        do_b();
        do_aw(4'd4, 32'h1C000200, 8'd1, 3'd3, 2'b11);
        send_beat(64'hE0, 8'hFF, 1'b0);
        checks++; if ({ram_wen, m_wready, m_bvalid} !== 10'b00000000_1_0) begin fails++; $display("FAIL rsvd_beat0: got %b expected 0000000010", {ram_wen, m_wready, m_bvalid}); end
        send_beat(64'hE1, 8'hFF, 1'b1);
        m_wvalid = 0;
        checks++; if (ram_wen !== 8'h00) begin fails++; $display("FAIL rsvd_beat1_wen: got %h expected 00", ram_wen); end
        checks++; if ({m_bvalid, m_bid, m_bresp} !== 7'b1_0100_10) begin fails++; $display("FAIL rsvd_b: got %b expected 1010010", {m_bvalid, m_bid, m_bresp}); end
        do_b();
    endtask

    task automatic test_backpressure();
        do_aw(4'd9, 32'h1C000300, 8'd0, 3'd3, 2'b01);
        send_beat(64'hF0, 8'hFF, 1'b1);
        m_wvalid = 0;
        for (int i = 0; i < 5; i++) begin
            checks++; if ({m_bvalid, m_bid, m_bresp, m_awready, m_wready} !== 9'b1_1001_00_00) begin fails++; $display("FAIL bp_hold%0d: got %b expected 110010000", i, {m_bvalid, m_bid, m_bresp, m_awready, m_wready}); end
            @(posedge aclk); #1;
        end
        do_b();
        checks++; if ({m_awready, m_bvalid} !== 2'b10) begin fails++; $display("FAIL bp_release: got %b expected 10", {m_awready, m_bvalid}); end
        do_aw(4'd1, 32'h1C000400, 8'd2, 3'd3, 2'b01);
        for (int i = 0; i < 3; i++) begin
            send_beat(64'h100 + 64'(i), 8'hFF, i == 2);
            m_wvalid = 0;
            checks++; if ({ram_waddr, ram_wen} !== {32'h1C000400 + 32'(8 * i), 8'hFF}) begin fails++; $display("FAIL gap_wr%0d: got %h expected %h", i, {ram_waddr, ram_wen}, {32'h1C000400 + 32'(8 * i), 8'hFF}); end
            if (i < 2) begin
                for (int g = 0; g < 2; g++) begin
                    @(posedge aclk); #1;
                    checks++; if ({ram_wen, m_wready, m_bvalid} !== 10'b00000000_1_0) begin fails++; $display("FAIL gap_idle%0d_%0d: got %b expected 0000000010", i, g, {ram_wen, m_wready, m_bvalid}); end
                end
            end
        end
        checks++; if ({m_bvalid, m_bresp} !== 3'b100) begin fails++; $display("FAIL gap_b: got %b expected 100", {m_bvalid, m_bresp}); end
        do_b();
    endtask

    task automatic test_midburst_reset();
        do_aw(4'd8, 32'h1C000500, 8'd7, 3'd3, 2'b01);
        for (int i = 0; i < 3; i++) send_beat(64'h200 + 64'(i), 8'hFF, 1'b0);
        m_wvalid = 0;
        areset = 1'b1;
        #1;
        checks++; if ({m_awready, m_wready, m_bvalid, m_bid, m_bresp} !== 9'h000) begin fails++; $display("FAIL arst_hs: got %b expected 000000000", {m_awready, m_wready, m_bvalid, m_bid, m_bresp}); end
        checks++; if ({ram_waddr, ram_wdata, ram_wen} !== 104'h0) begin fails++; $display("FAIL arst_ram: got %h expected 0", {ram_waddr, ram_wdata, ram_wen}); end
        @(posedge aclk); #1;
        areset = 1'b0;
        @(posedge aclk); #1;
        checks++; if ({m_awready, m_wready, m_bvalid} !== 3'b100) begin fails++; $display("FAIL arst_release: got %b expected 100", {m_awready, m_wready, m_bvalid}); end
        do_aw(4'd10, 32'h1C000600, 8'd0, 3'd3, 2'b01);
        send_beat(64'h55AA, 8'h3C, 1'b1);
        m_wvalid = 0;
        checks++; if ({ram_waddr, ram_wdata, ram_wen} !== {32'h1C000600, 64'h55AA, 8'h3C}) begin fails++; $display("FAIL arst_new_wr: got %h expected %h", {ram_waddr, ram_wdata, ram_wen}, {32'h1C000600, 64'h55AA, 8'h3C}); end
        checks++; if ({m_bvalid, m_bid, m_bresp} !== 7'b1_1010_00) begin fails++; $display("FAIL arst_new_b: got %b expected 1101000", {m_bvalid, m_bid, m_bresp}); end
        do_b();
        checks++; if (m_awready !== 1'b1) begin fails++; $display("FAIL arst_new_done: got %b expected 1", m_awready); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_incr();
        test_wrap_fixed();
        test_errors();
        test_backpressure();
        test_midburst_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
